// File: rtl/alu_flag_unit_if.sv
// ALU-result / flag / branch bundle between the Gumnut datapath and the flag unit.
// Latency: none, wires only.
// Backpressure: none; the flag unit accepts every request and never stalls.
//
// Signals:
//   alu_valid, alu_out, alu_cout, alu_vout, flag_we : ALU result and flag-write strobe
//   int_ack, reti                                   : interrupt entry / return pulses
//   br_req, br_cond                                 : branch evaluation request
//   br_valid, br_taken                              : registered branch response
//   z_flag, c_flag, v_flag (ALU_V_FLAG_EN)          : architectural flags
//   in_isr, seq_err                                 : ISR state and sticky protocol error
interface alu_flag_unit_if #(
   parameter int DATA_W = 8
);
   logic              alu_valid;
   logic [DATA_W-1:0] alu_out;
   logic              alu_cout;
   logic              alu_vout;
   logic              flag_we;
   logic              int_ack;
   logic              reti;
   logic              br_req;
   logic [2:0]        br_cond;
   logic              br_valid;
   logic              br_taken;
   logic              z_flag;
   logic              c_flag;
`ifdef ALU_V_FLAG_EN
   logic              v_flag;
`endif
   logic              in_isr;
   logic              seq_err;

   // Core side: drives ALU results and control pulses, observes flags/branch.
   modport master (
      output alu_valid, alu_out, alu_cout, alu_vout, flag_we,
      output int_ack, reti, br_req, br_cond,
      input  br_valid, br_taken, z_flag, c_flag,
`ifdef ALU_V_FLAG_EN
      input  v_flag,
`endif
      input  in_isr, seq_err
   );

   // Flag unit side.
   modport slave (
      input  alu_valid, alu_out, alu_cout, alu_vout, flag_we,
      input  int_ack, reti, br_req, br_cond,
      output br_valid, br_taken, z_flag, c_flag,
`ifdef ALU_V_FLAG_EN
      output v_flag,
`endif
      output in_isr, seq_err
   );
endinterface

// File: rtl/alu_flag_unit.sv
// Condition-flag register (Z, C, optional V) with branch resolution and ISR flag save/restore.
// Latency: flags and branch response are registered, visible one cycle after the sampling edge.
// Backpressure: none; every br_req yields a br_valid pulse the next cycle, back-to-back allowed.
//
// Ports:
//   clk   : core clock, all state on rising edge
//   rst_n : synchronous active-low reset
//   bus   : alu_flag_unit_if.slave (ALU result in, branch/flag/ISR status out)
// Build option: define ALU_V_FLAG_EN to add the overflow flag V, its shadow copy,
// the v_flag output and the bv/bnv branch conditions.
module alu_flag_unit #(
   parameter int DATA_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_flag_unit_if.slave bus
);

   typedef enum logic {
      ST_RUN = 1'b0,
      ST_ISR = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic z_q, z_d;
   logic c_q, c_d;
   logic zs_q, zs_d;           // shadow copies taken on interrupt entry
   logic cs_q, cs_d;
`ifdef ALU_V_FLAG_EN
   logic v_q, v_d;
   logic vs_q, vs_d;
`endif
   logic br_valid_q, br_valid_d;
   logic br_taken_q, br_taken_d;
   logic seq_err_q, seq_err_d;
   logic in_isr_q, in_isr_d;

   logic [DATA_W-1:0] res;
   logic              flag_wr;
   logic              z_post, c_post;   // flags as they stand after this cycle's ALU write
`ifdef ALU_V_FLAG_EN
   logic              v_post;
`else
   logic              unused_vout;
   assign unused_vout = bus.alu_vout;
`endif

   assign res     = bus.alu_out;
   assign flag_wr = bus.alu_valid & bus.flag_we;
   assign z_post  = flag_wr ? (res == '0) : z_q;
   assign c_post  = flag_wr ? bus.alu_cout : c_q;
`ifdef ALU_V_FLAG_EN
   assign v_post  = flag_wr ? bus.alu_vout : v_q;
`endif

   // Branches look only at the registered flags; a write in the same cycle
   // is deliberately not forwarded.
   always_comb begin
      br_valid_d = bus.br_req;
      br_taken_d = 1'b0;
      if (bus.br_req) begin
         case (bus.br_cond)
            3'b000:  br_taken_d = z_q;
            3'b001:  br_taken_d = ~z_q;
            3'b010:  br_taken_d = c_q;
            3'b011:  br_taken_d = ~c_q;
`ifdef ALU_V_FLAG_EN
            3'b100:  br_taken_d = v_q;
            3'b101:  br_taken_d = ~v_q;
`endif
            default: br_taken_d = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d   = state_q;
      z_d       = z_post;
      c_d       = c_post;
      zs_d      = zs_q;
      cs_d      = cs_q;
`ifdef ALU_V_FLAG_EN
      v_d       = v_post;
      vs_d      = vs_q;
`endif
      seq_err_d = seq_err_q;

      case (state_q)
         ST_RUN: begin
            if (bus.int_ack) begin
               // The interrupted instruction retires first, so the shadow
               // captures the post-write flags.
               zs_d    = z_post;
               cs_d    = c_post;
`ifdef ALU_V_FLAG_EN
               vs_d    = v_post;
`endif
               state_d = ST_ISR;
            end
            if (bus.reti) begin
               seq_err_d = 1'b1;
            end
         end
         ST_ISR: begin
            if (bus.reti) begin
               // Restore takes priority over any concurrent ALU flag write.
               z_d     = zs_q;
               c_d     = cs_q;
`ifdef ALU_V_FLAG_EN
               v_d     = vs_q;
`endif
               state_d = ST_RUN;
            end
            if (bus.int_ack) begin
               seq_err_d = 1'b1;   // no nesting, shadow left alone
            end
         end
         default: state_d = ST_RUN;
      endcase

      in_isr_d = (state_d == ST_ISR);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         z_q        <= 1'b0;
         c_q        <= 1'b0;
         zs_q       <= 1'b0;
         cs_q       <= 1'b0;
`ifdef ALU_V_FLAG_EN
         v_q        <= 1'b0;
         vs_q       <= 1'b0;
`endif
         br_valid_q <= 1'b0;
         br_taken_q <= 1'b0;
         seq_err_q  <= 1'b0;
         in_isr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         z_q        <= z_d;
         c_q        <= c_d;
         zs_q       <= zs_d;
         cs_q       <= cs_d;
`ifdef ALU_V_FLAG_EN
         v_q        <= v_d;
         vs_q       <= vs_d;
`endif
         br_valid_q <= br_valid_d;
         br_taken_q <= br_taken_d;
         seq_err_q  <= seq_err_d;
         in_isr_q   <= in_isr_d;
      end
   end

   assign bus.br_valid = br_valid_q;
   assign bus.br_taken = br_taken_q;
   assign bus.z_flag   = z_q;
   assign bus.c_flag   = c_q;
`ifdef ALU_V_FLAG_EN
   assign bus.v_flag   = v_q;
`endif
   assign bus.in_isr   = in_isr_q;
   assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Scoreboard bench for alu_flag_unit: driver pushes expected post-edge outputs,
// monitor pops and compares on the falling edge.
// Build option ALU_V_FLAG_EN is honoured the same way as in the design.
module tb_alu_flag_unit;

   logic clk;
   logic rst_n;

   alu_flag_unit_if #(.DATA_W(8)) bus ();

   alu_flag_unit #(.DATA_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef struct {
      flags_t f;
      logic   isr;
      logic   err;
      logic   bv;
      logic   bt;
   } exp_t;

   exp_t   exp_q[$];
   int     n_checks = 0;
   int     n_fail   = 0;

   // reference model state
   flags_t m_f, m_sh;
   logic   m_isr, m_err;

   // Condition code: bits [2:1] pick the flag (Z, C, V, reserved), bit 0 inverts.
   function automatic logic ref_taken(input logic [2:0] cd, input flags_t f);
      logic sel;
`ifdef ALU_V_FLAG_EN
      if (cd[2:1] == 2'd3) return 1'b0;
`else
      if (cd[2]) return 1'b0;
`endif
      sel = (cd[2:1] == 2'd0) ? f.z : (cd[2:1] == 2'd1) ? f.c : f.v;
      return sel ^ cd[0];
   endfunction

   task automatic chk(input string name, input logic act, input logic expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, expv, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("z_flag",   bus.z_flag,   e.f.z);
         chk("c_flag",   bus.c_flag,   e.f.c);
`ifdef ALU_V_FLAG_EN
         chk("v_flag",   bus.v_flag,   e.f.v);
`endif
         chk("in_isr",   bus.in_isr,   e.isr);
         chk("seq_err",  bus.seq_err,  e.err);
         chk("br_valid", bus.br_valid, e.bv);
         chk("br_taken", bus.br_taken, e.bt);
      end
   end

   // One clock: apply inputs, advance the model, push the post-edge expectation.
   task automatic cyc(input bit rn = 1, input bit av = 0, input bit we = 0,
                      input logic [7:0] o = 8'h00, input bit co = 0, input bit vo = 0,
                      input bit ia = 0, input bit rt = 0,
                      input bit br = 0, input logic [2:0] cd = 3'b000);
      exp_t   e;
      flags_t post;
      rst_n         = rn;
      bus.alu_valid = av;
      bus.flag_we   = we;
      bus.alu_out   = o;
      bus.alu_cout  = co;
      bus.alu_vout  = vo;
      bus.int_ack   = ia;
      bus.reti      = rt;
      bus.br_req    = br;
      bus.br_cond   = cd;

      if (!rn) begin
         m_f   = '0;
         m_sh  = '0;
         m_isr = 1'b0;
         m_err = 1'b0;
         e.bv  = 1'b0;
         e.bt  = 1'b0;
      end else begin
         e.bv = br;
         e.bt = br && ref_taken(cd, m_f);
         post = m_f;
         if (av && we) post = '{z: (o == 8'h00), c: co, v: vo};
         if (ia && !m_isr) begin
            m_sh  = post;
            m_f   = post;
            m_isr = 1'b1;
            if (rt) m_err = 1'b1;
         end else if (rt && m_isr) begin
            m_f   = m_sh;
            m_isr = 1'b0;
            if (ia) m_err = 1'b1;
         end else begin
            m_f = post;
            if (ia || rt) m_err = 1'b1;
         end
      end
      e.f   = m_f;
      e.isr = m_isr;
      e.err = m_err;

      @(posedge clk);
      exp_q.push_back(e);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.alu_valid = 0; bus.flag_we = 0; bus.alu_out = 0; bus.alu_cout = 0;
      bus.alu_vout = 0; bus.int_ack = 0; bus.reti = 0; bus.br_req = 0; bus.br_cond = 0;
      m_f = '0; m_sh = '0; m_isr = 0; m_err = 0;
      #2;

      // reset state
      cyc(.rn(0)); cyc(.rn(0));

      // basic flag writes
      cyc(.av(1), .we(1), .o(8'h00), .co(1));
      cyc(.av(1), .we(1), .o(8'h5A), .co(0));
      cyc(.av(1), .we(0), .o(8'h00), .co(1));
      cyc(.av(0), .we(1), .o(8'h00), .co(1));

      // branch sees pre-update Z; reserved code
      cyc(.av(1), .we(1), .o(8'h00));
      cyc(.av(1), .we(1), .o(8'h01), .br(1), .cd(3'b000));
      cyc(.br(1), .cd(3'b000));
      cyc(.br(1), .cd(3'b110));
      cyc(.br(1), .cd(3'b001));
      cyc(.br(1), .cd(3'b111));

      // save / restore
      cyc(.av(1), .we(1), .o(8'h00), .co(0));
      cyc(.ia(1));
      cyc(.av(1), .we(1), .o(8'h80), .co(1), .br(1), .cd(3'b010));
      cyc(.rt(1), .br(1), .cd(3'b011));
      cyc(.br(1), .cd(3'b000));

      // int_ack with write, reti with dropped write
      cyc(.av(1), .we(1), .o(8'h00), .co(1), .ia(1));
      cyc(.av(1), .we(1), .o(8'h33), .co(0));
      cyc(.av(1), .we(1), .o(8'h01), .co(0), .rt(1));
      cyc();

      // protocol errors and reset mid-ISR
      cyc(.rt(1));
      cyc(.rn(0));
      cyc(.ia(1));
      cyc(.ia(1));
      cyc(.av(1), .we(1), .o(8'h00), .co(1));
      cyc(.rn(0));
      cyc(.ia(1), .rt(1));
      cyc(.ia(1), .rt(1));

      // overflow flag and bv/bnv
      cyc(.rn(0));
      cyc(.av(1), .we(1), .o(8'h7F), .co(0), .vo(1));
      cyc(.br(1), .cd(3'b100));
      cyc(.br(1), .cd(3'b101));
      cyc(.av(1), .we(1), .o(8'h10), .vo(0), .br(1), .cd(3'b100));
      cyc(.br(1), .cd(3'b101));

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         cyc(.rn(($urandom % 150) != 0),
             .av(($urandom % 4) != 0),
             .we($urandom % 2),
             .o((($urandom % 4) == 0) ? 8'h00 : 8'($urandom)),
             .co($urandom % 2),
             .vo($urandom % 2),
             .ia(($urandom % 12) == 0),
             .rt(($urandom % 12) == 0),
             .br($urandom % 2),
             .cd(3'($urandom)));
      end

      cyc();
      @(posedge clk);
      @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_flag_unit.md
Name: alu_flag_unit

Overview:
- Consumes the ALU result interface (8-bit result, carry-out, overflow-out) on the Gumnut core datapath.
- Holds the architectural condition flags Z and C, plus V when compiled in.
- Resolves conditional branches from those flags with a registered valid/taken response.
- Saves flags on interrupt entry and restores them on reti, tracked by a two-state machine.

Parameters:
- DATA_W, 8, width of the ALU result used for zero detection.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- alu_valid  input  1  ALU result on alu_out/alu_cout/alu_vout is valid this cycle.
- alu_out  input  DATA_W  ALU result.
- alu_cout  input  1  ALU carry-out.
- alu_vout  input  1  ALU overflow-out.
- flag_we  input  1  current instruction updates flags; effective only with alu_valid.
- int_ack  input  1  one-cycle pulse, interrupt entry accepted.
- reti  input  1  one-cycle pulse, return from interrupt.
- br_req  input  1  branch condition evaluation request.
- br_cond  input  3  000 bz, 001 bnz, 010 bc, 011 bnc, 100 bv, 101 bnv, 11x reserved.
- br_valid  output  1  branch result valid; one-cycle pulse.
- br_taken  output  1  branch decision; meaningful when br_valid=1, else 0.
- z_flag  output  1  registered zero flag.
- c_flag  output  1  registered carry flag.
- in_isr  output  1  state machine is in ISR.
- seq_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - z_flag, c_flag, V, and the shadow flags clear to 0.
  - State goes to RUN; in_isr=0.
  - br_valid=0, br_taken=0, seq_err=0.
  - Reset overrides every other input, including an in-flight branch or ISR.
- Flag update: when alu_valid and flag_we are both 1:
  - Z <= (alu_out == 0).
  - C <= alu_cout.
  - V <= alu_vout (when V is compiled in).
  - No update otherwise.
- Branch resolution:
  - br_req sampled at edge N produces br_valid=1 during cycle N+1, for exactly one cycle.
  - Evaluation uses the flags registered before edge N. A same-cycle flag write is not bypassed.
  - Reserved codes, and V codes when V is not compiled in: br_valid=1, br_taken=0.
  - Back-to-back br_req gives back-to-back br_valid pulses. There is no stall.
- State machine, states RUN and ISR:
  - RUN, int_ack=1: shadow <= flags, then go to ISR.
  - ISR, reti=1: flags <= shadow, then go to RUN.
  - RUN, reti=1: ignored; seq_err <= 1.
  - ISR, int_ack=1: ignored (no nesting, shadow untouched); seq_err <= 1.
- Simultaneous events:
  - int_ack with a flag write in RUN: the shadow captures the post-update flags. The interrupted instruction completes first. The live flags also take the update.
  - reti with a flag write in ISR: restore wins; the flag write is dropped.
  - int_ack with reti in RUN: int_ack is taken, reti is flagged; go to ISR, seq_err=1.
  - int_ack with reti in ISR: reti is taken, int_ack is flagged; go to RUN, seq_err=1.
- seq_err stays set until reset.
- in_isr = (state == ISR), driven from a register.

Optional Feature:
- Macro: ALU_V_FLAG_EN.
- Defined:
  - Adds output port v_flag (1 bit, reset 0).
  - V is updated, saved, and restored alongside Z and C.
  - br_cond 100 is taken when V=1; 101 is taken when V=0.
- Undefined:
  - No v_flag port and no V or shadow-V storage.
  - alu_vout is ignored.
  - br_cond 100 and 101 behave as reserved (br_taken=0).

Test Plan:
- Reset, then alu_valid=1, flag_we=1, alu_out=8'h00, alu_cout=1 -> next cycle z_flag=1, c_flag=1. Then alu_out=8'h5A, alu_cout=0 -> z_flag=0, c_flag=0. With flag_we=0 and alu_out=0 -> flags unchanged.
- Set Z=1, then br_req with br_cond=000 while a flag write of alu_out=8'h01 occurs in the same cycle -> next cycle br_valid=1, br_taken=1 (pre-update Z). A following bz -> br_taken=0. br_cond=110 -> br_valid=1, br_taken=0.
- Flags Z=1, C=0; int_ack -> in_isr=1. In ISR write alu_out=8'h80, alu_cout=1 -> Z=0, C=1. Then reti -> Z=1, C=0, in_isr=0, seq_err=0.
- int_ack with a same-cycle flag write (alu_out=0, cout=1) -> shadow holds Z=1, C=1. In ISR clear flags, then reti with a same-cycle write (alu_out=8'h01) -> Z=1, C=1 (write dropped).
- reti in RUN -> seq_err=1, flags and state unchanged. Reset -> seq_err=0. int_ack twice -> second ignored, seq_err=1. Then rst_n=0 while in ISR -> in_isr=0 and all flags 0 after the edge.
- With ALU_V_FLAG_EN: alu_vout=1 write -> v_flag=1, bv taken, bnv not taken. Without the macro: bv gives br_valid=1, br_taken=0.
